// File: rtl/note_envelope_pwm.sv
// Shapes a 1-bit square-wave tone with an ADSR envelope via PWM gating; gate is 2-FF synchronised.
// Latency: spk_out registered 1 cycle after tone_in, gate_in reaches the FSM in 2-3 cycles; no backpressure.
module note_envelope_pwm #(
    parameter int LEVEL_W       = 8,
    parameter int TICK_DIV      = 50000,
    parameter int ATTACK_STEP   = 8,
    parameter int DECAY_STEP    = 2,
    parameter int SUSTAIN_LEVEL = 160,
    parameter int RELEASE_STEP  = 4
) (
    input  logic               CLOCK_50,
    input  logic               RST_N,
    input  logic               tone_in,
    input  logic               gate_in,
    output logic               spk_out,
    output logic [LEVEL_W-1:0] env_level,
    output logic [1:0]         env_state,
    output logic               busy
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [LEVEL_W-1:0] LMAX      = '1;
    localparam logic [LEVEL_W-1:0] SUS_L     = LEVEL_W'(SUSTAIN_LEVEL);
    localparam logic [LEVEL_W:0]   A_STEP    = (LEVEL_W+1)'(ATTACK_STEP);
    localparam logic [LEVEL_W:0]   D_STEP    = (LEVEL_W+1)'(DECAY_STEP);
    localparam logic [LEVEL_W:0]   R_STEP    = (LEVEL_W+1)'(RELEASE_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ATTACK,
        S_DECAY,
        S_SUSTAIN,
        S_RELEASE
    } state_t;

    logic               gate_meta_q, gate_s_q;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic               tick;
    logic [LEVEL_W-1:0] pwm_cnt_q;
    logic [LEVEL_W-1:0] level_q;
    state_t             state_q;
    logic               spk_q;

    logic [LEVEL_W:0]   up_sum, dec_diff, rel_diff;
    logic [LEVEL_W-1:0] up_lvl, dec_lvl, rel_lvl;

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            gate_meta_q <= 1'b0;
            gate_s_q    <= 1'b0;
        end else begin
            gate_meta_q <= gate_in;
            gate_s_q    <= gate_meta_q;
        end
    end

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            tick_cnt_q <= '0;
            pwm_cnt_q  <= '0;
            spk_q      <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            pwm_cnt_q  <= pwm_cnt_q + LEVEL_W'(1);
            spk_q      <= tone_in & (pwm_cnt_q < level_q);
        end
    end

    // Steps are taken one bit wider so overflow/underflow shows up in the MSB and saturates.
    always_comb begin
        up_sum   = {1'b0, level_q} + A_STEP;
        dec_diff = {1'b0, level_q} - D_STEP;
        rel_diff = {1'b0, level_q} - R_STEP;
        up_lvl   = up_sum[LEVEL_W] ? LMAX : up_sum[LEVEL_W-1:0];
        dec_lvl  = (dec_diff[LEVEL_W] || (dec_diff[LEVEL_W-1:0] < SUS_L)) ? SUS_L : dec_diff[LEVEL_W-1:0];
        rel_lvl  = rel_diff[LEVEL_W] ? '0 : rel_diff[LEVEL_W-1:0];
    end

    // Gate-driven transitions take priority over a coincident tick, so that tick applies no step.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            level_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gate_s_q) state_q <= S_ATTACK;
                end
                S_ATTACK: begin
                    if (!gate_s_q) begin
                        state_q <= S_RELEASE;
                    end else if (tick) begin
                        level_q <= up_lvl;
                        if (up_lvl == LMAX) state_q <= S_DECAY;
                    end
                end
                S_DECAY: begin
                    if (!gate_s_q) begin
                        state_q <= S_RELEASE;
                    end else if (tick) begin
                        level_q <= dec_lvl;
                        if (dec_lvl == SUS_L) state_q <= S_SUSTAIN;
                    end
                end
                S_SUSTAIN: begin
                    if (!gate_s_q) state_q <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (gate_s_q) begin
                        state_q <= S_ATTACK;
                    end else if (tick) begin
                        level_q <= rel_lvl;
                        if (rel_lvl == '0) state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    level_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        env_state = 2'd0;
        case (state_q)
            S_ATTACK:            env_state = 2'd1;
            S_DECAY, S_SUSTAIN:  env_state = 2'd2;
            S_RELEASE:           env_state = 2'd3;
            default:             env_state = 2'd0;
        endcase
    end

    assign env_level = level_q;
    assign busy      = (state_q != S_IDLE);
    assign spk_out   = spk_q;

endmodule

// File: tb/tb_note_envelope_pwm.sv
// Directed checks of note_envelope_pwm: envelope trajectory table, PWM duty, async reset, full-scale duty.
module tb_note_envelope_pwm;

    logic       clk;
    logic       rst_n, gate_in, tone_in;
    logic       spk;
    logic [7:0] lvl;
    logic [1:0] st;
    logic       busy;

    logic       rst2_n, gate2, tone2;
    logic       spk2;
    logic [7:0] lvl2;
    logic [1:0] st2;
    logic       busy2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cyc2  = 0;

    note_envelope_pwm #(.LEVEL_W(8), .TICK_DIV(4)) u_dut (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .tone_in  (tone_in),
        .gate_in  (gate_in),
        .spk_out  (spk),
        .env_level(lvl),
        .env_state(st),
        .busy     (busy)
    );

    // Sustain at full scale so the LMAX duty can be observed for a long stretch.
    note_envelope_pwm #(.LEVEL_W(8), .TICK_DIV(4), .SUSTAIN_LEVEL(255)) u_dut2 (
        .CLOCK_50 (clk),
        .RST_N    (rst2_n),
        .tone_in  (tone2),
        .gate_in  (gate2),
        .spk_out  (spk2),
        .env_level(lvl2),
        .env_state(st2),
        .busy     (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        int   lvl;
        int   st;
        logic gate_nxt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int c, int l, int s, logic g);
        vec_t v;
        v.cyc      = c;
        v.lvl      = l;
        v.st       = s;
        v.gate_nxt = g;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic go_to(input int target);
        while (cyc < target) begin
            step();
            cyc++;
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            go_to(vecs[i].cyc);
            chk("env_level", int'(lvl), vecs[i].lvl);
            chk("env_state", int'(st), vecs[i].st);
            chk("busy", int'(busy), (vecs[i].st != 0) ? 1 : 0);
            gate_in = vecs[i].gate_nxt;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int duty;
        int exp_spk;
        logic t;

        vecs.push_back(mk(2,    0,   0, 1'b1));
        vecs.push_back(mk(3,    0,   1, 1'b1));
        vecs.push_back(mk(4,    8,   1, 1'b1));
        vecs.push_back(mk(7,    8,   1, 1'b1));
        vecs.push_back(mk(8,    16,  1, 1'b1));
        vecs.push_back(mk(124,  248, 1, 1'b1));
        vecs.push_back(mk(127,  248, 1, 1'b1));
        vecs.push_back(mk(128,  255, 2, 1'b1));
        vecs.push_back(mk(132,  253, 2, 1'b1));
        vecs.push_back(mk(316,  161, 2, 1'b1));
        vecs.push_back(mk(320,  160, 2, 1'b1));
        vecs.push_back(mk(600,  160, 2, 1'b0));
        vecs.push_back(mk(602,  160, 2, 1'b0));
        vecs.push_back(mk(603,  160, 3, 1'b0));
        vecs.push_back(mk(604,  156, 3, 1'b0));
        vecs.push_back(mk(756,  4,   3, 1'b0));
        vecs.push_back(mk(760,  0,   0, 1'b0));
        vecs.push_back(mk(800,  0,   0, 1'b1));
        vecs.push_back(mk(803,  0,   1, 1'b1));
        vecs.push_back(mk(832,  64,  1, 1'b0));
        vecs.push_back(mk(835,  64,  3, 1'b0));
        vecs.push_back(mk(836,  60,  3, 1'b0));
        vecs.push_back(mk(864,  32,  3, 1'b1));
        vecs.push_back(mk(867,  32,  1, 1'b1));
        vecs.push_back(mk(868,  40,  1, 1'b1));
        vecs.push_back(mk(872,  48,  1, 1'b1));
        vecs.push_back(mk(877,  56,  1, 1'b0));
        vecs.push_back(mk(879,  56,  1, 1'b0));
        vecs.push_back(mk(880,  56,  3, 1'b0));
        vecs.push_back(mk(884,  52,  3, 1'b0));
        vecs.push_back(mk(885,  52,  3, 1'b1));
        vecs.push_back(mk(887,  52,  3, 1'b1));
        vecs.push_back(mk(888,  52,  1, 1'b1));
        vecs.push_back(mk(892,  60,  1, 1'b1));
        vecs.push_back(mk(988,  252, 1, 1'b1));
        vecs.push_back(mk(992,  255, 2, 1'b1));
        vecs.push_back(mk(1184, 160, 2, 1'b1));
        vecs.push_back(mk(1290, 160, 2, 1'b1));

        rst_n   = 1'b0;
        gate_in = 1'b1;
        tone_in = 1'b1;
        rst2_n  = 1'b0;
        gate2   = 1'b1;
        tone2   = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset spk_out", int'(spk), 0);
        chk("reset env_level", int'(lvl), 0);
        chk("reset env_state", int'(st), 0);
        chk("reset busy", int'(busy), 0);
        rst_n = 1'b1;
        cyc   = 0;

        run_vecs(0, 10);

        // Steady sustain at 160: one full PWM period should give exactly 160 high clocks.
        duty = 0;
        for (int c = 330; c <= 585; c++) begin
            go_to(c);
            duty += int'(spk);
        end
        chk("sustain duty", duty, 160);

        run_vecs(11, 16);

        for (int c = 761; c <= 799; c++) begin
            go_to(c);
            chk("idle spk_out", int'(spk), 0);
        end

        run_vecs(17, 37);

        chk("sustain spk_out high", int'(spk), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset spk_out", int'(spk), 0);
        chk("async reset env_level", int'(lvl), 0);
        chk("async reset env_state", int'(st), 0);
        chk("async reset busy", int'(busy), 0);

        @(negedge clk);
        rst2_n = 1'b1;
        cyc2   = 0;
        for (int c = 1; c <= 140; c++) begin
            step();
            cyc2 = c;
        end
        chk("full-scale env_level", int'(lvl2), 255);
        chk("full-scale env_state", int'(st2), 2);

        for (int c = 141; c <= 740; c++) begin
            t = ((c / 50) % 2 == 0);
            tone2 = t;
            step();
            cyc2 = c;
            exp_spk = (t && (((c - 1) % 256) != 255)) ? 1 : 0;
            chk("full-scale spk_out", int'(spk2), exp_spk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
